mipi_rx_packet_decoder: RTL and testbench

MIPI_RX_PACKET_DECODER -- requirements
Module: mipi_rx_packet_decoder

---
 rtl/mipi_rx_packet_decoder.sv | 134 +++++++++++++
 tb/tb_mipi_rx_packet_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 packet decoder on an aligned 4-lane byte stream: one header per HS burst,
// then the long-packet payload with byte enables; the trailing checksum is dropped.
module mipi_rx_packet_decoder #(
  parameter bit ECC_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        validin,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        ecc_error,
  output logic [31:0] dout,
  output logic [3:0]  dkeep,
  output logic        dvalid,
  output logic        dlast,
  output logic        trunc_error
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_IDLE} state_t;

  state_t      r_state, w_state_nxt;
  logic [16:0] r_rem, w_rem_nxt;
  logic [16:0] w_rem_m2;
  logic [2:0]  w_pb;
  logic [3:0]  w_keep;
  logic [5:0]  w_ecc_calc;
  logic        w_ecc_err, w_long;
  logic        w_hdr_valid, w_dvalid, w_trunc;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  assign w_ecc_calc = ecc6(din[23:0]);
  assign w_ecc_err  = (din[31:24] != {2'b00, w_ecc_calc});
  assign w_long     = (din[5:0] >= 6'h10);

  // rem counts payload + 2 checksum bytes; payload bytes left is rem-2 floored at 0
  assign w_rem_m2 = (r_rem > 17'd2) ? (r_rem - 17'd2) : 17'd0;
  assign w_pb     = (w_rem_m2 >= 17'd4) ? 3'd4 : w_rem_m2[2:0];

  always_comb begin
    w_keep = 4'b0000;
    case (w_pb)
      3'd1:    w_keep = 4'b0001;
      3'd2:    w_keep = 4'b0011;
      3'd3:    w_keep = 4'b0111;
      3'd4:    w_keep = 4'b1111;
      default: w_keep = 4'b0000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_hdr_valid = 1'b0;
    w_dvalid    = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (validin) begin
          w_hdr_valid = 1'b1;
          if (ECC_CHECK && w_ecc_err) begin
            w_state_nxt = WAIT_IDLE;
          end else if (w_long) begin
            w_rem_nxt   = {1'b0, din[23:8]} + 17'd2;
            w_state_nxt = PAYLOAD;
          end else begin
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (validin) begin
          w_dvalid = (w_pb != 3'd0);
          if (r_rem <= 17'd4) w_state_nxt = WAIT_IDLE;
          else                w_rem_nxt   = r_rem - 17'd4;
        end else begin
          w_trunc     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!validin) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      hdr_valid   <= 1'b0;
      hdr_di      <= '0;
      hdr_wc      <= '0;
      hdr_long    <= 1'b0;
      ecc_error   <= 1'b0;
      dout        <= '0;
      dkeep       <= '0;
      dvalid      <= 1'b0;
      dlast       <= 1'b0;
      trunc_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      hdr_valid   <= w_hdr_valid;
      dvalid      <= w_dvalid;
      trunc_error <= w_trunc;
      if (w_hdr_valid) begin
        hdr_di    <= din[7:0];
        hdr_wc    <= {din[23:16], din[15:8]};
        hdr_long  <= w_long;
        ecc_error <= w_ecc_err;
      end
      if (w_dvalid) begin
        dout  <= din;
        dkeep <= w_keep;
        dlast <= (w_rem_m2 <= 17'd4);
      end
    end
  end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Scoreboard bench for mipi_rx_packet_decoder: stimulus tasks push expected
// header/payload/truncation events with their due cycle; a negedge monitor pops them.
module tb_mipi_rx_packet_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        validin;
  logic        hdr_valid, hdr_long, ecc_error, dvalid, dlast, trunc_error;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [31:0] dout;
  logic [3:0]  dkeep;

  mipi_rx_packet_decoder #(.ECC_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .validin(validin),
    .hdr_valid(hdr_valid), .hdr_di(hdr_di), .hdr_wc(hdr_wc), .hdr_long(hdr_long),
    .ecc_error(ecc_error), .dout(dout), .dkeep(dkeep), .dvalid(dvalid),
    .dlast(dlast), .trunc_error(trunc_error)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] di; logic [15:0] wc; logic lng; logic err; } hexp_t;
  typedef struct { int cyc; logic [31:0] d; logic [3:0] keep; logic last; } dexp_t;

  hexp_t hq[$];
  dexp_t dq[$];
  int    tq[$];
  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;

  // per-bit syndrome columns of the CSI-2 header Hamming code
  logic [5:0] ECC_TAB [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_TAB[i];
    return e;
  endfunction

  function automatic logic [3:0] keep_of(input int pb);
    case (pb)
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    validin = v;
    din     = d;
  endtask

  // One burst: header, nw words, then idle; expected results pushed as driven.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int nw,
                          input bit flip);
    logic [23:0] d;
    logic [7:0]  e;
    logic [31:0] w;
    bit          lng, ok;
    int          rem, pb;
    d   = {wc[15:8], wc[7:0], di};
    e   = {2'b00, ecc_of(d)};
    if (flip) e ^= 8'h01;
    lng = (di[5:0] >= 6'h10);
    ok  = !flip;
    drive(1'b1, {e, d});
    hq.push_back('{cyc + 1, di, wc, lng, flip});
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      drive(1'b1, w);
      rem = int'(wc) + 2 - 4 * k;
      if (lng && ok && rem > 0) begin
        pb = rem - 2;
        if (pb > 4) pb = 4;
        if (pb > 0) dq.push_back('{cyc + 1, w, keep_of(pb), (rem - 2) <= 4});
      end
    end
    drive(1'b0, $urandom);
    if (lng && ok && (int'(wc) + 2 - 4 * nw) > 0) tq.push_back(cyc + 1);
    drive(1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) begin
        if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
        else begin
          hexp_t h;
          h = hq.pop_front();
          chk("hdr_cyc", cyc, h.cyc);
          chk("hdr_di", hdr_di, h.di);
          chk("hdr_wc", hdr_wc, h.wc);
          chk("hdr_long", hdr_long, h.lng);
          chk("ecc_error", ecc_error, h.err);
        end
      end
      if (dvalid) begin
        if (dq.size() == 0) chk("dvalid_unexpected", 1, 0);
        else begin
          dexp_t x;
          x = dq.pop_front();
          chk("d_cyc", cyc, x.cyc);
          chk("dout", dout, x.d);
          chk("dkeep", dkeep, x.keep);
          chk("dlast", dlast, x.last);
        end
      end
      if (trunc_error) begin
        if (tq.size() == 0) chk("trunc_unexpected", 1, 0);
        else chk("trunc_cyc", cyc, tq.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] hd;
    logic [31:0] w1;
    rst = 1'b1; validin = 1'b0; din = '0;
    #1;
    chk("rst_hdr", {hdr_valid, hdr_di, hdr_wc, hdr_long, ecc_error}, 0);
    chk("rst_dat", {dout, dkeep, dvalid, dlast, trunc_error}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 32'h0);

    send_pkt(8'h00, 16'h0000, 0, 0);         // FS short packet
    send_pkt(8'h2B, 16'd6, 2, 0);            // RAW10 style, keep 1111 then 0011
    chk("hold_dkeep", dkeep, 4'b0011);
    chk("hold_dlast", dlast, 1'b1);
    chk("hold_di", hdr_di, 8'h2B);
    send_pkt(8'h2A, 16'd4, 2, 0);            // payload word + checksum-only word
    send_pkt(8'h2B, 16'd8, 3, 1);            // flipped ECC: no payload
    send_pkt(8'h2C, 16'd16, 2, 0);           // truncated after 2 words
    send_pkt(8'h01, 16'h1234, 1, 0);         // next burst decodes normally
    send_pkt(8'h2A, 16'd0, 2, 0);            // WC=0: checksum word, then ignored word
    send_pkt(8'h24, 16'd3, 3, 0);            // keep 0111 last, then checksum word
    send_pkt(8'h64, 16'd5, 3, 0);            // VC=1, keep 1111 then 0001 last
    send_pkt(8'hEB, 16'hFFFF, 3, 0);         // max WC, truncated
    for (int i = 0; i < 6; i++)
      send_pkt({2'($urandom), 6'($urandom_range(0, 15))}, 16'($urandom), 1, 0);

    // asynchronous reset in the middle of a payload
    hd = {8'h00, 8'd16, 8'h2B};
    w1 = $urandom;
    drive(1'b1, {2'b00, ecc_of(hd), hd});
    hq.push_back('{cyc + 1, 8'h2B, 16'd16, 1'b1, 1'b0});
    drive(1'b1, w1);
    dq.push_back('{cyc + 1, w1, 4'b1111, 1'b0});
    drive(1'b1, $urandom);
    @(posedge clk);
    #2;
    rst = 1'b1;
    validin = 1'b0;
    #1;
    chk("midrst_hdr", {hdr_valid, hdr_di, hdr_wc, hdr_long, ecc_error}, 0);
    chk("midrst_dat", {dout, dkeep, dvalid, dlast, trunc_error}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_pkt(8'h12, 16'hBEEF, 0, 0);
    send_pkt(8'h2B, 16'd2, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("hq_left", hq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("tq_left", tq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
